// File: rtl/path_reader.sv
// path_reader: drains the direction stack into a local buffer, then replays the moves
// start-to-goal over a valid/ready port. Define PATH_READER_COORD_EN to track mv_x/mv_y.
module path_reader #(
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 256,
    parameter int COORD_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               stk_empty,
    input  logic [WIDTH-1:0]   stk_dout,
    output logic               stk_pop,
    output logic               mv_valid,
    input  logic               mv_ready,
    output logic [WIDTH-1:0]   mv_dir,
    output logic [COORD_W-1:0] mv_x,
    output logic [COORD_W-1:0] mv_y,
    output logic               busy,
    output logic               done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPTURE,
        S_REPLAY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    rd_q, rd_d;
    logic             mv_valid_q, mv_valid_d;
    logic [WIDTH-1:0] mv_dir_q, mv_dir_d;
    logic             hs;
    logic             last_mv;
    logic [AW-1:0]    rd_idx;

    assign hs      = mv_valid_q & mv_ready;
    assign last_mv = (rd_q == ONE);
    // Index of the move that follows the one currently presented (buf[rd-2]).
    assign rd_idx  = AW'(rd_q - TWO);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = stk_empty ? S_DONE : S_POP;
                end
            end
            S_POP:     state_d = S_CAPTURE;
            S_CAPTURE: state_d = stk_empty ? S_REPLAY : S_POP;
            S_REPLAY: begin
                if (hs && last_mv) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stk_pop = (state_q == S_POP);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
    end

    // The final CAPTURE forwards stk_dout straight to the output, since it is the first move.
    always_comb begin
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        mv_valid_d = mv_valid_q;
        mv_dir_d   = mv_dir_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                end
            end
            S_CAPTURE: begin
                cnt_d = cnt_q + ONE;
                if (stk_empty) begin
                    rd_d       = cnt_q + ONE;
                    mv_valid_d = 1'b1;
                    mv_dir_d   = stk_dout;
                end
            end
            S_REPLAY: begin
                if (hs) begin
                    rd_d = rd_q - ONE;
                    if (last_mv) begin
                        mv_valid_d = 1'b0;
                    end else begin
                        mv_dir_d = buf_q[rd_idx];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q      <= '0;
            rd_q       <= '0;
            mv_valid_q <= 1'b0;
            mv_dir_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            mv_valid_q <= mv_valid_d;
            mv_dir_q   <= mv_dir_d;
        end
    end

    // Buffer contents are don't-care outside a drain/replay, so no reset.
    always_ff @(posedge CLK) begin
        if (state_q == S_CAPTURE) begin
            buf_q[cnt_q[AW-1:0]] <= stk_dout;
        end
    end

    assign mv_valid = mv_valid_q;
    assign mv_dir   = mv_dir_q;

`ifdef PATH_READER_COORD_EN
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    function automatic logic [COORD_W-1:0] step_x(input logic [COORD_W-1:0] x,
                                                  input logic [WIDTH-1:0]   d);
        case (d)
            2'b01:   return x + COORD_W'(1);
            2'b10:   return x - COORD_W'(1);
            default: return x;
        endcase
    endfunction

    function automatic logic [COORD_W-1:0] step_y(input logic [COORD_W-1:0] y,
                                                  input logic [WIDTH-1:0]   d);
        case (d)
            2'b00:   return y - COORD_W'(1);
            2'b11:   return y + COORD_W'(1);
            default: return y;
        endcase
    endfunction

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if ((state_q == S_IDLE) && start) begin
            x_d = '0;
            y_d = '0;
        end else if (((state_q == S_CAPTURE) && stk_empty) ||
                     ((state_q == S_REPLAY) && hs && !last_mv)) begin
            x_d = step_x(x_q, mv_dir_d);
            y_d = step_y(y_q, mv_dir_d);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign mv_x = x_q;
    assign mv_y = y_q;
`else
    assign mv_x = '0;
    assign mv_y = '0;
`endif

endmodule

// File: tb/tb_path_reader.sv
// tb_path_reader: randomized drain/replay traffic against a queue model of the
// direction stack and of the expected start-to-goal move sequence.
`timescale 1ns/1ps
module tb_path_reader;
    localparam int WIDTH   = 2;
    localparam int DEPTH   = 256;
    localparam int COORD_W = 4;
    localparam int AW      = $clog2(DEPTH);
    localparam int MODV    = 1 << COORD_W;
`ifdef PATH_READER_COORD_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0]   d;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } mv_t;

    logic               CLK = 1'b0;
    logic               RST;
    logic               start;
    logic               stk_empty;
    logic [WIDTH-1:0]   stk_dout = '0;
    logic               stk_pop;
    logic               mv_valid;
    logic               mv_ready;
    logic [WIDTH-1:0]   mv_dir;
    logic [COORD_W-1:0] mv_x;
    logic [COORD_W-1:0] mv_y;
    logic               busy;
    logic               done;

    logic               push_en;
    logic [WIDTH-1:0]   push_d;
    logic [WIDTH-1:0]   smem [DEPTH];
    int                 sp = 0;

    int                 nchecks = 0;
    int                 nerrors = 0;
    int                 pop_total = 0;
    int                 done_total = 0;
    logic [WIDTH-1:0]   mstk[$];
    logic [WIDTH-1:0]   path[$];
    mv_t                got[$];

    path_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COORD_W(COORD_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .stk_empty(stk_empty),
        .stk_dout(stk_dout), .stk_pop(stk_pop), .mv_valid(mv_valid),
        .mv_ready(mv_ready), .mv_dir(mv_dir), .mv_x(mv_x), .mv_y(mv_y),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Direction stack: data appears the cycle after a pop, empty flag reflects post-pop depth.
    always @(posedge CLK) begin
        if (push_en) begin
            smem[sp[AW-1:0]] <= push_d;
            sp <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_dout <= smem[sp[AW-1:0] - 1'b1];
            sp <= sp - 1;
        end
    end
    assign stk_empty = (sp == 0);

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic mv_t mk(input logic [WIDTH-1:0] d, input int x, input int y);
        mv_t m;
        m.d = d;
        m.x = CE ? COORD_W'(x) : '0;
        m.y = CE ? COORD_W'(y) : '0;
        return m;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_stk_pop"},  32'(stk_pop),  0);
        check({tag, "_mv_valid"}, 32'(mv_valid), 0);
        check({tag, "_mv_dir"},   32'(mv_dir),   0);
        check({tag, "_mv_x"},     32'(mv_x),     0);
        check({tag, "_mv_y"},     32'(mv_y),     0);
        check({tag, "_busy"},     32'(busy),     0);
        check({tag, "_done"},     32'(done),     0);
    endtask

    // Phase model: 0 idle, 1 draining, 2 replaying, 3 done pulse.
    task automatic monitor();
        int  mode = 0;
        int  t = 0;
        int  n = 0;
        int  x, y, dx, dy;
        mv_t expq[$];
        mv_t prev_m = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST) begin
                mode = 0;
                expq.delete();
                check_all_zero("reset");
            end else begin
                case (mode)
                    0: begin
                        if (start) begin
                            n = mstk.size();
                            if (n == 0) begin
                                mode = 3;
                            end else begin
                                x = 0;
                                y = 0;
                                foreach (mstk[i]) begin
                                    dx = (mstk[i] == 2'b01) ? 1 : (mstk[i] == 2'b10) ? -1 : 0;
                                    dy = (mstk[i] == 2'b11) ? 1 : (mstk[i] == 2'b00) ? -1 : 0;
                                    x = (x + dx + MODV) % MODV;
                                    y = (y + dy + MODV) % MODV;
                                    expq.push_back(mk(mstk[i], x, y));
                                end
                                mstk.delete();
                                t = 0;
                                mode = 1;
                            end
                        end
                    end
                    1: begin
                        t++;
                        if (t == 2 * n) mode = 2;
                    end
                    2: begin
                        if (mv_ready) begin
                            got.push_back(prev_m);
                            void'(expq.pop_front());
                            if (expq.size() == 0) mode = 3;
                        end
                    end
                    default: mode = 0;
                endcase
                check("stk_pop",  32'(stk_pop),  32'((mode == 1) && (t % 2 == 0)));
                check("mv_valid", 32'(mv_valid), 32'(mode == 2));
                check("busy",     32'(busy),     32'(mode != 0));
                check("done",     32'(done),     32'(mode == 3));
                if (mode == 2) begin
                    check("mv_dir", 32'(mv_dir), 32'(expq[0].d));
                    check("mv_x",   32'(mv_x),   32'(expq[0].x));
                    check("mv_y",   32'(mv_y),   32'(expq[0].y));
                end
                if (stk_pop === 1'b1) pop_total++;
                if (done === 1'b1) done_total++;
            end
            prev_m = {mv_dir, mv_x, mv_y};
        end
    endtask

    task automatic push_all();
        foreach (path[i]) begin
            @(negedge CLK);
            push_en = 1'b1;
            push_d  = path[i];
            mstk.push_back(path[i]);
        end
        @(negedge CLK);
        push_en = 1'b0;
    endtask

    task automatic rand_path(input int len);
        path.delete();
        for (int i = 0; i < len; i++) path.push_back(WIDTH'($urandom_range(3)));
    endtask

    task automatic wait_done(input int d0, input string tag);
        int c = 0;
        while (done_total == d0 && c < 2000) begin
            @(negedge CLK);
            c++;
        end
        check({tag, "_done_count"}, 32'(done_total - d0), 1);
        @(negedge CLK);
    endtask

    task automatic run(input int rdy_pct, input bit disturb, input string tag);
        int d0;
        int c = 0;
        d0 = done_total;
        @(negedge CLK);
        start    = 1'b1;
        mv_ready = ($urandom_range(99) < rdy_pct);
        while (1) begin
            @(negedge CLK);
            c++;
            if (done_total != d0 || c >= 2000) break;
            start    = disturb && ($urandom_range(3) == 0);
            mv_ready = ($urandom_range(99) < rdy_pct);
        end
        start = 1'b0;
        check({tag, "_done_count"}, 32'(done_total - d0), 1);
        @(negedge CLK);
    endtask

    task automatic check_path(input int p0, input string tag);
        check({tag, "_pops"},  32'(pop_total - p0), 32'(path.size()));
        check({tag, "_moves"}, 32'(got.size()),     32'(path.size()));
        foreach (path[i]) check({tag, "_dir"}, 32'(got[i].d), 32'(path[i]));
    endtask

    initial begin
        int p0;
        int d0;
        int c;
        RST      = 1'b1;
        start    = 1'b0;
        mv_ready = 1'b0;
        push_en  = 1'b0;
        push_d   = '0;
        #1 RST = 1'b0;
        fork
            monitor();
        join_none
        @(negedge CLK);
        @(negedge CLK);
        check_all_zero("por");
        RST = 1'b1;

        // Empty stack: immediate done, nothing popped or presented.
        path.delete();
        p0 = pop_total;
        got.delete();
        run(100, 1'b0, "empty");
        check_path(p0, "empty");

        // Right, right, down.
        path = '{2'b01, 2'b01, 2'b11};
        push_all();
        p0 = pop_total;
        got.delete();
        run(100, 1'b0, "rrd");
        check_path(p0, "rrd");
        check("rrd_m0", 32'(got[0]), 32'(mk(2'b01, 1, 0)));
        check("rrd_m1", 32'(got[1]), 32'(mk(2'b01, 2, 0)));
        check("rrd_m2", 32'(got[2]), 32'(mk(2'b11, 2, 1)));

        // Same path, downstream stalls on the second move.
        push_all();
        got.delete();
        d0 = done_total;
        mv_ready = 1'b1;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        c = 0;
        while (got.size() < 1 && c < 50) begin
            @(negedge CLK);
            c++;
        end
        check("stall_first_hs", 32'(got.size()), 1);
        mv_ready = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("stall_valid", 32'(mv_valid), 1);
            check("stall_move", 32'({mv_dir, mv_x, mv_y}), 32'(mk(2'b01, 2, 0)));
        end
        mv_ready = 1'b1;
        wait_done(d0, "stall");
        check("stall_moves", 32'(got.size()), 3);
        check("stall_m2", 32'(got[2]), 32'(mk(2'b11, 2, 1)));

        // Single left move wraps x.
        path = '{2'b10};
        push_all();
        p0 = pop_total;
        got.delete();
        run(100, 1'b0, "wrap");
        check_path(p0, "wrap");
        check("wrap_m0", 32'(got[0]), 32'(mk(2'b10, 15, 0)));

        // Reset while a 4-move replay is stalled.
        rand_path(4);
        push_all();
        mv_ready = 1'b0;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        c = 0;
        while (mv_valid !== 1'b1 && c < 50) begin
            @(negedge CLK);
            c++;
        end
        check("midrst_reach_replay", 32'(mv_valid), 1);
        RST = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge CLK);
        RST = 1'b1;
        path.delete();
        p0 = pop_total;
        got.delete();
        run(100, 1'b0, "after_rst");
        check_path(p0, "after_rst");

        // Extra start pulses while busy must not disturb anything.
        rand_path(6);
        push_all();
        p0 = pop_total;
        got.delete();
        run(70, 1'b1, "disturb");
        check_path(p0, "disturb");

        for (int k = 0; k < 25; k++) begin
            rand_path($urandom_range(0, 12));
            push_all();
            p0 = pop_total;
            got.delete();
            run($urandom_range(30, 100), 1'($urandom_range(1)), "rand");
            check_path(p0, "rand");
        end

        // Completely full stack.
        rand_path(DEPTH);
        push_all();
        p0 = pop_total;
        got.delete();
        run(100, 1'b0, "full");
        check_path(p0, "full");

        @(negedge CLK);
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/path_reader.md
# path_reader

Reads the maze solver's direction stack back out once a path has been found, then replays it to downstream logic in forward (start-to-goal) order. It sits on the read side of the direction stack, the LIFO of 2-bit moves pushed during the search. It pops every entry into a local buffer, then emits one move per valid/ready handshake together with the running cell coordinates. Downstream consumers are the path display and the move counter.

## Interface
- WIDTH, 2, bits per stored move; matches stack entry width
- DEPTH, 256, maximum moves buffered; matches stack depth
- COORD_W, 4, coordinate width per axis (16x16 maze)

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- start  in  1  begin drain+replay; sampled only in IDLE
- stk_empty  in  1  stack empty flag
- stk_dout  in  WIDTH  stack data, valid the cycle after a pop
- stk_pop  out  1  pop request to stack, one cycle per entry
- mv_valid  out  1  move output valid
- mv_ready  in  1  downstream accepts move
- mv_dir  out  WIDTH  move direction
- mv_x  out  COORD_W  x after applying mv_dir
- mv_y  out  COORD_W  y after applying mv_dir
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of replay

## Operation
- Direction encoding: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1).
- Start cell is (0,0).
- Coordinates wrap modulo 2^COORD_W, so left from x=0 gives x=2^COORD_W-1.
- States: IDLE, POP, CAPTURE, REPLAY, DONE.
- IDLE:
  - start=1 and stk_empty=1 -> DONE.
  - start=1 and stk_empty=0 -> POP.
  - Clear cnt and coordinates on leaving IDLE.
- POP: stk_pop=1 (decoded from state), -> CAPTURE.
- CAPTURE:
  - buf[cnt] <= stk_dout; cnt <= cnt+1.
  - If stk_empty (post-pop) -> REPLAY with rd=cnt (new count), else -> POP.
- buf[0] holds the last move pushed, so replay reads from buf[cnt-1] down to buf[0].
- REPLAY:
  - Present mv_dir=buf[rd-1] with mv_x/mv_y already updated; mv_valid=1.
  - On mv_valid&&mv_ready: rd <= rd-1 and load the next move with its coordinates.
  - After the move at buf[0] is accepted -> DONE.
- DONE: done=1 for one cycle, -> IDLE.
- cnt and rd are clog2(DEPTH)+1 bits wide. cnt never exceeds DEPTH because the stack cannot hold more.
- start while busy=1 is ignored.
- stk_pop is never asserted outside POP.
- Contents of buf are not cleared by reset and are don't-care in IDLE.

## Timing
- Reset values: stk_pop=0, mv_valid=0, mv_dir=0, mv_x=0, mv_y=0, busy=0, done=0, state IDLE.
- Reset mid-operation returns to IDLE immediately. The partially drained stack is not restored.
- Drain of N entries takes 2N cycles (POP/CAPTURE per entry).
- First mv_valid is asserted in the cycle after the final CAPTURE.
- Throughput is one move per cycle while mv_ready=1.
- mv_valid, mv_dir, mv_x and mv_y are registered and held stable while mv_valid=1 and mv_ready=0.
- mv_valid never drops without a handshake, except on reset.
- Empty stack at start: done rises 1 cycle after the start edge; no pop and no mv_valid.
- done rises the cycle after the final handshake; busy falls the cycle after done.

## Configuration
- PATH_READER_COORD_EN defined:
  - Coordinate tracking adders and registers are present.
  - mv_x/mv_y behave as specified.
- Not defined:
  - mv_x and mv_y are tied to 0.
  - Coordinate registers are removed.
  - All other behaviour, including cycle timing, is unchanged.

## Test plan
- Empty stack, pulse start -> no stk_pop; done=1 exactly 1 cycle after start; mv_valid stays 0.
- Push 01,01,11 into stack, start, mv_ready=1:
  - 3 stk_pop pulses over 6 cycles.
  - Moves (01,1,0), (01,2,0), (11,2,1) on consecutive cycles, then done.
- Same path with mv_ready=0 for 5 cycles on the second move -> mv_valid=1 and dir=01, x=2, y=0 held stable; resumes when ready returns.
- Push single 10 (left), COORD_W=4 -> one move with x=15, y=0 (wrap).
- Assert RST low during REPLAY of a 4-move path -> all outputs 0 at once, state IDLE; start with now-empty stack -> done pulse, no moves.
- Pulse start again during POP/REPLAY -> ignored; pop count and move sequence identical to an undisturbed run.
